lab1_pio_led_out: RTL



---
 rtl/lab1_pio_led_out_pkg.sv | 15 +
 rtl/lab1_pio_led_out_if.sv | 25 ++
 rtl/lab1_pio_blink_timer.sv | 39 +++
 rtl/lab1_pio_led_out.sv | 82 ++++++++
 4 files changed

// File: rtl/lab1_pio_led_out_pkg.sv
// Shared constants for the LED output PIO: bus width and register word addresses.
// Imported by the bus interface, the blink timer and the top.
package lab1_pio_pkg;

  localparam int BUS_W = 32;
  localparam int ADDR_W = 3;

  localparam logic [ADDR_W-1:0] ADDR_DATA     = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_MASK     = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_PERIOD   = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_OUTSET   = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_OUTCLEAR = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_LIVE     = 3'd5;

endpackage

// File: rtl/lab1_pio_led_out_if.sv
// Avalon-MM slave bus bundle for the LED PIO; no waitrequest, no read strobe.
// readdata is registered in the slave, one cycle after address.
interface lab1_pio_led_out_if;
  import lab1_pio_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              write;
  logic [BUS_W-1:0]  writedata;
  logic [BUS_W-1:0]  readdata;

  modport master (
    output address,
    output write,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  write,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/lab1_pio_blink_timer.sv
// Blink phase generator: phase toggles every `period` cycles; period 0 holds phase low.
// A load strobe restarts the count with phase low; no backpressure.
module lab1_pio_blink_timer
  import lab1_pio_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [BUS_W-1:0] period,
  input  logic             load,
  output logic             phase,
  output logic [BUS_W-1:0] cnt
);

  logic [BUS_W-1:0] r_cnt;
  logic             r_phase;

  // Comparing against period-1 keeps cnt below period, so it can never wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (load) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (period == '0) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (r_cnt == period - 32'd1) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + 32'd1;
    end
  end

  assign phase = r_phase;
  assign cnt   = r_cnt;

endmodule

// File: rtl/lab1_pio_led_out.sv
// LED output PIO: data register with set/clear, per-bit blink mask and blink timer.
// Writes visible on out_port one cycle later; readdata is registered (1-cycle read latency).
module lab1_pio_led_out
  import lab1_pio_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter logic [BUS_W-1:0] PERIOD_RESET = '0
) (
  input  logic                clk,
  input  logic                reset,
  lab1_pio_led_out_if.slave   bus,
  output logic [WIDTH-1:0]    out_port
);

  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_mask;
  logic [BUS_W-1:0] r_period;
  logic [BUS_W-1:0] r_readdata;

  logic [WIDTH-1:0] w_wdata;
  logic             w_load;
  logic             w_phase;
  logic [WIDTH-1:0] w_out;
  logic [BUS_W-1:0] w_rd_mux;
  logic [BUS_W-1:0] w_unused_cnt;

  assign w_wdata = bus.writedata[WIDTH-1:0];
  assign w_load  = bus.write && (bus.address == ADDR_PERIOD);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data   <= RESET_VALUE;
      r_mask   <= '0;
      r_period <= PERIOD_RESET;
    end else if (bus.write) begin
      case (bus.address)
        ADDR_DATA:     r_data   <= w_wdata;
        ADDR_MASK:     r_mask   <= w_wdata;
        ADDR_PERIOD:   r_period <= bus.writedata;
        ADDR_OUTSET:   r_data   <= r_data | w_wdata;
        ADDR_OUTCLEAR: r_data   <= r_data & ~w_wdata;
        default:       ;
      endcase
    end
  end

  lab1_pio_blink_timer u_blink_timer (
    .clk    (clk),
    .reset  (reset),
    .period (r_period),
    .load   (w_load),
    .phase  (w_phase),
    .cnt    (w_unused_cnt)
  );

  // Driven from registers only, so no bus input reaches the pins combinationally.
  assign w_out    = r_data ^ (r_mask & {WIDTH{w_phase}});
  assign out_port = w_out;

  always_comb begin
    w_rd_mux = '0;
    case (bus.address)
      ADDR_DATA:   w_rd_mux = BUS_W'(r_data);
      ADDR_MASK:   w_rd_mux = BUS_W'(r_mask);
      ADDR_PERIOD: w_rd_mux = r_period;
      ADDR_LIVE:   w_rd_mux = BUS_W'(w_out);
      default:     w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_readdata <= '0;
    end else begin
      r_readdata <= w_rd_mux;
    end
  end

  assign bus.readdata = r_readdata;

endmodule
